// File: rtl/pipeline_inject_pkg.sv
// Shared types and helpers for the clocked front end that injects words into the micropipeline.
// Covers the FSM state encoding, pointer sizing and the round-robin pick.
package pipeline_inject_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Searches upward from ptr and wraps at n, which need not be a power of two.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int n,
                                                 input logic [3:0] ptr);
    logic [MAX_REQ-1:0] pick;
    logic found;
    int idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[3:0]]) begin
          pick[idx[3:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pipeline_inject_arbiter_sync.sv
// Flop-chain synchronizer for an asynchronous 4-phase handshake wire.
// The same block is meant to sit on the pipeline output side (rr/ra).
module handshake_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pipeline_inject_arbiter.sv
// Round-robin front end that shares the micropipeline input channel between
// N_REQ clocked requesters, one word per 4-phase lr/la transaction.
//
// state | meaning
// IDLE  | waiting for a request with the synchronized acknowledge low
// SETUP | word held on data_o, counting out the bundling margin
// REQ   | lr_o high, waiting for the acknowledge
// RTZ   | lr_o low, waiting for the acknowledge to return to zero
module pipeline_inject_arbiter
  import pipeline_inject_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   lr_o,
  input  logic                   la_i,
  output logic                   busy_o
);

  localparam int PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  logic [SYNC_STAGES-1:0] rst_pipe;
  logic                   rst_q;
  logic                   la_s;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, win_idx;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               lr_nxt;
  logic               load;
  logic [MAX_REQ-1:0] req_ext, pick;
  logic [N_REQ-1:0]   gnt_v;
  logic [WIDTH-1:0]   win_data;
  logic               pick_unused;

  // Async assert, sync release; depth matches the la chain so la_s is valid
  // in the first cycle the FSM runs and a stale acknowledge is never missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= '1;
    else     rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_q = rst_pipe[SYNC_STAGES-1];

  handshake_sync #(
    .STAGES (SYNC_STAGES)
  ) u_la_sync (
    .clk (clk),
    .rst (rst),
    .d   (la_i),
    .q   (la_s)
  );

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req_i;
    pick     = rr_pick(req_ext, N_REQ, 4'(rr_ptr));
    win_idx  = '0;
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick[k]) begin
        win_idx  = PTR_W'(k);
        win_data = data_i[k*WIDTH +: WIDTH];
      end
    end
    rr_ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  assign pick_unused = ^pick;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lr_nxt    = lr_o;
    load      = 1'b0;
    gnt_v     = '0;
    case (state)
      IDLE: begin
        if ((|req_i) && !la_s) begin
          gnt_v     = pick[N_REQ-1:0];
          load      = 1'b1;
          cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          lr_nxt    = 1'b1;
          state_nxt = REQ;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      REQ: begin
        if (la_s) begin
          lr_nxt    = 1'b0;
          state_nxt = RTZ;
        end
      end
      RTZ: begin
        if (!la_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      lr_o   <= 1'b0;
      data_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lr_o  <= lr_nxt;
      if (load) begin
        data_o <= win_data;
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

  // The grant is combinational in IDLE, so it must be masked while reset is held.
  assign gnt_o  = rst_q ? '0 : gnt_v;
  assign busy_o = (state != IDLE);

endmodule
